// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: MMIO register offsets, STATUS bit positions and the
// address-decode result type shared by the data-memory slave.
package dmem_mmio_pkg;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [3:0] OFS_TX     = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_TOHOST = 4'h8;
    localparam logic [3:0] OFS_CYCLE  = 4'hC;

    // STATUS register layout
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_MMIO,
        DEC_UNMAPPED
    } decode_t;

endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: MEM-stage load/store bus plus the console TX drain port.
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output MemWrite, DataAdr, WriteData, tx_ready,
        input  ReadData, tx_data, tx_valid
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, tx_ready,
        output ReadData, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_fifo.sv
// byte_fifo: byte FIFO with registered head, sticky overflow and a
// push that is accepted at full when a pop happens on the same edge.
module byte_fifo #(
    parameter int FIFO_DEPTH = 8,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    pushData,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr, wrPtr, nextRd;
    logic          doPush, doPop;

    assign full   = count == CW'(FIFO_DEPTH);
    assign empty  = count == '0;
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign nextRd = doPop ? rdPtr + PW'(1) : rdPtr;

    // Storage array; contents are discarded by resetting the pointers/count
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    // Pointers, occupancy, sticky overflow and the registered head byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            head     <= '0;
        end else begin
            rdPtr <= nextRd;
            if (doPush) wrPtr <= wrPtr + PW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
            if (push && !doPush) overflow <= 1'b1;
            // The byte being written this edge may itself become the new head
            head <= (doPush && wrPtr == nextRd) ? pushData : mem[nextRd];
        end
    end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus MMIO window (console TX FIFO,
// TOHOST/halt, cycle counter). Loads are combinational from DataAdr.
// Build option: DMEM_MMIO_CYCLE_CNT_EN instantiates the CYCLE counter;
// without it offset 0xC reads 0 and writes there are ignored.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_mmio_if.slave        bus,
    output logic              halt,
    output logic [31:0]       tohost_value,
    output logic              err
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   ram [DEPTH_WORDS];
    decode_t       dec;
    logic          aligned, mmioWr, wrRam, wrTx, wrTohost, wrBad;
    logic          fifoFull, fifoEmpty, fifoOvf;
    logic [CW-1:0] fifoCount;
    logic [7:0]    fifoHead;
    logic [31:0]   statusWord, cycleRd;

    // Address decode: RAM at the bottom, 16-byte MMIO window at MMIO_BASE
    always_comb begin
        dec = DEC_UNMAPPED;
        if (bus.DataAdr < RAM_BYTES)                     dec = DEC_RAM;
        else if (bus.DataAdr[31:4] == MMIO_BASE[31:4])   dec = DEC_MMIO;
    end

    assign aligned  = bus.DataAdr[1:0] == 2'b00;
    assign mmioWr   = bus.MemWrite && aligned && dec == DEC_MMIO;
    assign wrRam    = bus.MemWrite && aligned && dec == DEC_RAM;
    assign wrTx     = mmioWr && bus.DataAdr[3:0] == OFS_TX;
    assign wrTohost = mmioWr && bus.DataAdr[3:0] == OFS_TOHOST;
    assign wrBad    = bus.MemWrite && (!aligned || dec == DEC_UNMAPPED);

    // Data RAM is not reset
    always_ff @(posedge clk) begin
        if (wrRam) ram[bus.DataAdr[AW+1:2]] <= bus.WriteData;
    end

    // Sticky error flag and first-write-wins TOHOST capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err          <= 1'b0;
            halt         <= 1'b0;
            tohost_value <= '0;
        end else begin
            if (wrBad) err <= 1'b1;
            if (wrTohost && !halt) begin
                halt         <= 1'b1;
                tohost_value <= bus.WriteData;
            end
        end
    end

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (wrTx),
        .pushData (bus.WriteData[7:0]),
        .pop      (bus.tx_valid && bus.tx_ready),
        .head     (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .overflow (fifoOvf)
    );

    assign bus.tx_data  = fifoHead;
    assign bus.tx_valid = !fifoEmpty;

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [31:0] cycleCnt;
    logic        wrCycle;
    assign wrCycle = mmioWr && bus.DataAdr[3:0] == OFS_CYCLE;

    // Free-running cycle counter; a write clears it on that edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cycleCnt <= '0;
        else if (wrCycle) cycleCnt <= '0;
        else              cycleCnt <= cycleCnt + 32'd1;
    end
    assign cycleRd = cycleCnt;
`else
    assign cycleRd = '0;
`endif

    // STATUS word assembly
    always_comb begin
        statusWord                   = '0;
        statusWord[ST_FULL]          = fifoFull;
        statusWord[ST_EMPTY]         = fifoEmpty;
        statusWord[ST_OVF]           = fifoOvf;
        statusWord[ST_CNT_LSB +: 8]  = 8'(fifoCount);
    end

    // Combinational load path; misaligned and unmapped loads return 0
    always_comb begin
        bus.ReadData = '0;
        if (aligned) begin
            case (dec)
                DEC_RAM:  bus.ReadData = ram[bus.DataAdr[AW+1:2]];
                DEC_MMIO: begin
                    case (bus.DataAdr[3:0])
                        OFS_TX:     bus.ReadData = {24'b0, 8'(fifoCount)};
                        OFS_STATUS: bus.ReadData = statusWord;
                        OFS_TOHOST: bus.ReadData = tohost_value;
                        OFS_CYCLE:  bus.ReadData = cycleRd;
                        default:    bus.ReadData = '0;
                    endcase
                end
                default:  bus.ReadData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: scoreboard bench for dmem_mmio. Load results and console
// bytes are queued when stimulus is driven and compared when they appear.
module tb_dmem_mmio;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;
    localparam int          FDEP  = 8;

    logic        clk;
    logic        reset_n;
    logic        halt;
    logic [31:0] tohost_value;
    logic        err;

    dmem_mmio_if bus();

    dmem_mmio #(.DEPTH_WORDS(256), .FIFO_DEPTH(FDEP), .MMIO_BASE(MMIO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .halt         (halt),
        .tohost_value (tohost_value),
        .err          (err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rdQ[$];
    logic [7:0]  txQ[$];
    int          modelCount = 0;
    logic        modelOvf   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] statusExp();
        logic [31:0] s;
        s       = '0;
        s[0]    = (modelCount == FDEP);
        s[1]    = (modelCount == 0);
        s[2]    = modelOvf;
        s[15:8] = 8'(modelCount);
        return s;
    endfunction

    // All bus tasks are entered at a falling edge and return at the next one
    task automatic busWrite(input logic [31:0] adr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = adr;
        bus.WriteData = data;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
    endtask

    task automatic busRead(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        bus.MemWrite = 1'b0;
        bus.DataAdr  = adr;
        rdQ.push_back(exp);
        #1;
        check(tag, bus.ReadData, rdQ.pop_front());
        @(negedge clk);
    endtask

    task automatic txWrite(input logic [7:0] b);
        logic accept;
        accept = (modelCount < FDEP) || (bus.tx_ready && modelCount != 0);
        if (accept) begin
            txQ.push_back(b);
            modelCount++;
        end else begin
            modelOvf = 1'b1;
        end
        busWrite(MMIO + 32'h0, {24'h0, b});
    endtask

    task automatic modelReset();
        txQ.delete();
        modelCount = 0;
        modelOvf   = 1'b0;
    endtask

    // Console consumer: every handshake must deliver the oldest queued byte
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (bus.tx_valid && bus.tx_ready) begin
                check("tx_pending", 32'(txQ.size() != 0), 32'd1);
                if (txQ.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(txQ.pop_front()));
                modelCount--;
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.tx_ready  = 1'b0;
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_halt",     32'(halt), 0);
        check("rst_tohost",   tohost_value, 0);
        check("rst_err",      32'(err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // RAM store then load on the very next cycle
        busWrite(32'h0000_0000, 32'h0BAD_F00D);
        busWrite(32'h0000_0010, 32'hDEAD_BEEF);
        busRead("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        check("err_after_ram", 32'(err), 0);

        // STATUS is read-only and a write there is silently ignored
        busWrite(MMIO + 32'h4, 32'hFFFF_FFFF);
        check("err_status_wr", 32'(err), 0);
        busRead("status_empty", MMIO + 32'h4, statusExp());
        busRead("tx_cnt_empty", MMIO + 32'h0, 32'h0);

        // Misaligned and unmapped stores are dropped and flag err
        busWrite(32'h0000_0012, 32'h1234_5678);
        check("err_misaligned", 32'(err), 1);
        busRead("ram_keep_10", 32'h0000_0010, 32'hDEAD_BEEF);
        busRead("rd_misaligned", 32'h0000_0012, 32'h0);
        busWrite(32'h0000_0400, 32'hCAFE_CAFE);
        busRead("ram_keep_0", 32'h0000_0000, 32'h0BAD_F00D);
        busRead("rd_unmapped", 32'h0000_0400, 32'h0);
        check("err_sticky", 32'(err), 1);

        // TOHOST: first write wins
        busWrite(MMIO + 32'h8, 32'd1);
        check("halt_1", 32'(halt), 1);
        check("tohost_1", tohost_value, 32'd1);
        busWrite(MMIO + 32'h8, 32'd5);
        check("halt_2", 32'(halt), 1);
        check("tohost_2", tohost_value, 32'd1);
        busRead("tohost_rd", MMIO + 32'h8, 32'd1);

        // Fill past capacity with the consumer stalled
        for (int i = 0; i < 9; i++) txWrite(8'h41 + 8'(i));
        busRead("status_ovf", MMIO + 32'h4, 32'h0000_0805);
        busRead("tx_cnt_full", MMIO + 32'h0, 32'h0000_0008);
        bus.tx_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("drain_valid_7", 32'(bus.tx_valid), 1);
        @(negedge clk);
        check("drain_valid_8", 32'(bus.tx_valid), 0);
        check("drain_left", 32'(txQ.size()), 0);
        bus.tx_ready = 1'b0;

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 4; i++) txWrite(8'h61 + 8'(i));
        bus.tx_ready = 1'b1;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(bus.tx_valid), 0);
        check("arst_halt", 32'(halt), 0);
        check("arst_err", 32'(err), 0);
        modelReset();
        bus.tx_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        busRead("status_post_rst", MMIO + 32'h4, 32'h0000_0002);

        // Push into a full FIFO on the same edge as a pop
        for (int i = 0; i < 8; i++) txWrite(8'h30 + 8'(i));
        bus.tx_ready = 1'b1;
        txWrite(8'h38);
        bus.tx_ready = 1'b0;
        busRead("status_full_pp", MMIO + 32'h4, statusExp());
        busRead("status_full_lit", MMIO + 32'h4, 32'h0000_0801);
        bus.tx_ready = 1'b1;
        repeat (8) @(negedge clk);
        bus.tx_ready = 1'b0;
        check("pp_drain_left", 32'(txQ.size()), 0);
        check("pp_drain_valid", 32'(bus.tx_valid), 0);

`ifdef DMEM_MMIO_CYCLE_CNT_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        busRead("cycle_100", MMIO + 32'hC, 32'd100);
        busWrite(MMIO + 32'hC, 32'hFFFF_FFFF);
        busRead("cycle_clr", MMIO + 32'hC, 32'd0);
        busRead("cycle_after", MMIO + 32'hC, 32'd1);
        check("cycle_err", 32'(err), 0);
`else
        repeat (20) @(negedge clk);
        busRead("cycle_off", MMIO + 32'hC, 32'd0);
        busWrite(MMIO + 32'hC, 32'hFFFF_FFFF);
        busRead("cycle_off_wr", MMIO + 32'hC, 32'd0);
        check("cycle_off_err", 32'(err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
